// File: rtl/vjtag_dr_responder.sv
// User-side data-register responder for a virtual JTAG hub instance.
// Decodes the latched virtual IR and runs the selected DR, all in the tck domain.
module vjtag_dr_responder #(
    parameter int                DATA_W     = 16,
    parameter logic [31:0]       ID_VALUE   = 32'h5A1E_0001,
    parameter logic [DATA_W-1:0] CTRL_RESET = '0
) (
    input  logic              tck,
    input  logic              reset,
    input  logic              tdi,
    output logic              tdo,
    input  logic [4:0]        ir_in,
    output logic [4:0]        ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_e1dr,
    input  logic              virtual_state_pdr,
    input  logic              virtual_state_e2dr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_cir,
    input  logic              virtual_state_uir,
    input  logic [DATA_W-1:0] status_in,
    output logic [DATA_W-1:0] ctrl_reg,
    output logic              ctrl_strobe,
    output logic              err_len
);

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_WRITE  = 5'h02;
    localparam logic [4:0] IR_READ   = 5'h03;
    localparam logic [4:0] IR_CLR    = 5'h04;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_PAUSED} state_t;

    state_t              r_state, w_state_nxt;
    logic [4:0]          r_ir_q, w_ir_nxt;
    logic [31:0]         r_sr, w_sr_nxt, w_sr_shift, w_sr_dn;
    logic [5:0]          r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_ctrl, w_ctrl_nxt;
    logic                r_strobe, w_strobe_nxt;
    logic                r_err, w_err_nxt;
    logic [4:0]          r_ir_out;
    logic [5:0]          w_len;
    logic [31:0]         w_cap;
    logic                w_unused;

    // e1dr never changes state; the hub strobe is accepted and dropped
    assign w_unused = virtual_state_e1dr;

    always_comb begin
        w_len = 6'd1;
        w_cap = '0;
        case (r_ir_q)
            IR_IDCODE: begin w_len = 6'd32;       w_cap = ID_VALUE;          end
            IR_WRITE:  begin w_len = 6'(DATA_W);  w_cap = 32'(r_ctrl);       end
            IR_READ:   begin w_len = 6'(DATA_W);  w_cap = 32'(status_in);    end
            IR_CLR:    begin w_len = 6'd1;        w_cap = {31'b0, r_err};    end
            default:   begin w_len = 6'd1;        w_cap = '0;                end
        endcase
    end

    // LSB-first shift over the low L bits only; bits at or above L hold
    assign w_sr_dn = {1'b0, r_sr[31:1]};
    always_comb begin
        w_sr_shift = r_sr;
        for (int i = 0; i < 32; i++) begin
            if (i == int'(w_len) - 1)
                w_sr_shift[i] = tdi;
            else if (i < int'(w_len) - 1)
                w_sr_shift[i] = w_sr_dn[i];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sr_nxt     = r_sr;
        w_cnt_nxt    = r_cnt;
        w_ctrl_nxt   = r_ctrl;
        w_strobe_nxt = 1'b0;
        w_err_nxt    = r_err;
        w_ir_nxt     = virtual_state_uir ? ir_in : r_ir_q;
        if (virtual_state_cir) begin
            w_state_nxt = S_IDLE;
        end else if (virtual_state_cdr) begin
            w_state_nxt = S_ACTIVE;
            w_sr_nxt    = w_cap;
            w_cnt_nxt   = '0;
        end else if (virtual_state_udr && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            case (r_ir_q)
                IR_WRITE: begin
                    if (r_cnt == 6'(DATA_W)) begin
                        w_ctrl_nxt   = r_sr[DATA_W-1:0];
                        w_strobe_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                IR_CLR:  if (r_sr[0]) w_err_nxt = 1'b0;
                default: ;
            endcase
        end else if (virtual_state_sdr && r_state == S_ACTIVE) begin
            w_sr_nxt  = w_sr_shift;
            w_cnt_nxt = (r_cnt == 6'd63) ? r_cnt : r_cnt + 6'd1;
        end else if (virtual_state_pdr && r_state == S_ACTIVE) begin
            w_state_nxt = S_PAUSED;
        end else if (virtual_state_e2dr && r_state == S_PAUSED) begin
            w_state_nxt = S_ACTIVE;
        end
    end

    always_ff @(posedge tck) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            r_ir_q   <= '0;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_ctrl   <= CTRL_RESET;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
            r_ir_out <= '0;
        end else begin
            r_ir_q   <= w_ir_nxt;
            r_sr     <= w_sr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_strobe <= w_strobe_nxt;
            r_err    <= w_err_nxt;
            // built from next-state values so it tracks the FSM without lag
            r_ir_out <= {3'b000, w_err_nxt, w_state_nxt != S_IDLE};
        end
    end

    assign tdo         = r_sr[0];
    assign ir_out      = r_ir_out;
    assign ctrl_reg    = r_ctrl;
    assign ctrl_strobe = r_strobe;
    assign err_len     = r_err;

endmodule

// File: tb/tb_vjtag_dr_responder.sv
// Randomized and directed bench for vjtag_dr_responder; the reference model
// treats the DR as a bit queue (pop at tdo, push tdi at the far end).
module tb_vjtag_dr_responder;

    localparam int          DW   = 16;
    localparam logic [31:0] IDV  = 32'h5A1E_0001;
    localparam logic [7:0]  CDR  = 8'h01, SDR = 8'h02, E1 = 8'h04, PDR = 8'h08,
                            E2   = 8'h10, UDR = 8'h20, CIR = 8'h40, UIR = 8'h80;

    logic          tck = 1'b0;
    logic          rst = 1'b1;
    logic          tdi = 1'b0;
    logic          tdo;
    logic [4:0]    ir_in = '0;
    logic [4:0]    ir_out;
    logic          s_cdr = 0, s_sdr = 0, s_e1 = 0, s_pdr = 0, s_e2 = 0, s_udr = 0, s_cir = 0, s_uir = 0;
    logic [DW-1:0] status_in = '0;
    logic [DW-1:0] ctrl_reg;
    logic          ctrl_strobe;
    logic          err_len;

    int vectors = 0;
    int miscompares = 0;

    vjtag_dr_responder #(.DATA_W(DW), .ID_VALUE(IDV), .CTRL_RESET('0)) dut (
        .tck(tck), .reset(rst), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(s_cdr), .virtual_state_sdr(s_sdr), .virtual_state_e1dr(s_e1),
        .virtual_state_pdr(s_pdr), .virtual_state_e2dr(s_e2), .virtual_state_udr(s_udr),
        .virtual_state_cir(s_cir), .virtual_state_uir(s_uir),
        .status_in(status_in), .ctrl_reg(ctrl_reg), .ctrl_strobe(ctrl_strobe), .err_len(err_len)
    );

    always #5 tck = ~tck;

    // reference model: 0 idle, 1 active, 2 paused
    int          m_state = 0;
    logic [4:0]  m_ir = '0;
    bit          m_q[$];
    int          m_cnt = 0;
    logic [31:0] m_ctrl = '0;
    bit          m_strobe = 0;
    bit          m_err = 0;

    function automatic int mlen(input logic [4:0] ir);
        if (ir == 5'h01) return 32;
        if (ir == 5'h02 || ir == 5'h03) return DW;
        return 1;
    endfunction

    function automatic logic [31:0] mcap(input logic [4:0] ir);
        case (ir)
            5'h01:   return IDV;
            5'h02:   return m_ctrl;
            5'h03:   return 32'(status_in);
            5'h04:   return {31'b0, m_err};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic [7:0] st);
        int          len;
        logic [31:0] cap, v;
        logic [4:0]  nir;
        if (rst) begin
            m_state = 0; m_ir = '0; m_q = '{1'b0}; m_cnt = 0;
            m_ctrl = '0; m_strobe = 0; m_err = 0;
            return;
        end
        len = mlen(m_ir);
        cap = mcap(m_ir);
        nir = (st & UIR) != 0 ? ir_in : m_ir;
        m_strobe = 0;
        if ((st & CIR) != 0) begin
            m_state = 0;
        end else if ((st & CDR) != 0) begin
            m_state = 1; m_cnt = 0; m_q = {};
            for (int i = 0; i < len; i++) m_q.push_back(cap[i]);
        end else if ((st & UDR) != 0 && m_state != 0) begin
            m_state = 0;
            if (m_ir == 5'h02) begin
                if (m_cnt == DW) begin
                    v = '0;
                    foreach (m_q[i]) v[i] = m_q[i];
                    m_ctrl = v; m_strobe = 1;
                end else m_err = 1;
            end else if (m_ir == 5'h04 && m_q[0]) m_err = 0;
        end else if ((st & SDR) != 0 && m_state == 1) begin
            void'(m_q.pop_front());
            m_q.push_back(tdi);
            if (m_cnt < 63) m_cnt++;
        end else if ((st & PDR) != 0 && m_state == 1) m_state = 2;
        else if ((st & E2) != 0 && m_state == 2) m_state = 1;
        m_ir = nir;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] st, input logic d, input logic r = 1'b0);
        {s_uir, s_cir, s_udr, s_e2, s_pdr, s_e1, s_sdr, s_cdr} = st;
        tdi = d;
        rst = r;
        model_edge(st);
        @(posedge tck); #1;
        {s_uir, s_cir, s_udr, s_e2, s_pdr, s_e1, s_sdr, s_cdr} = '0;
        chk("tdo", 32'(tdo), 32'(m_q[0]));
        chk("ctrl_reg", 32'(ctrl_reg), m_ctrl);
        chk("ctrl_strobe", 32'(ctrl_strobe), 32'(m_strobe));
        chk("err_len", 32'(err_len), 32'(m_err));
        chk("ir_out", 32'(ir_out), {27'b0, 3'b000, m_err, m_state != 0});
    endtask

    // endk: 0 = update, 1 = cir abort, 2 = reset abort
    task automatic scan(input logic [4:0] ir, input int n, input logic [31:0] data,
                        input int pause_at, input int endk);
        ir_in = ir;
        cyc(UIR, 1'b0);
        cyc(CDR, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) begin
                cyc(E1, 1'b0);
                repeat (5) cyc(PDR, 1'b0);
                cyc(E2, 1'b0);
            end
            cyc(SDR, data[i % 32]);
        end
        case (endk)
            0:       begin cyc(E1, 1'b0); cyc(UDR, 1'b0); end
            1:       cyc(CIR, 1'b0);
            default: cyc(8'h00, 1'b0, 1'b1);
        endcase
        cyc(8'h00, 1'b0);
    endtask

    initial begin
        int          pick, len, n, pa, ek;
        logic [4:0]  ir;
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        chk("reset_ctrl", 32'(ctrl_reg), 32'h0);
        chk("reset_irout", 32'(ir_out), 32'h0);
        cyc(8'h00, 1'b0);

        scan(5'h01, 32, 32'h0, -1, 0);
        chk("idcode_ctrl", 32'(ctrl_reg), 32'h0);
        scan(5'h02, 16, 32'hBEEF, -1, 0);
        chk("write_beef", 32'(ctrl_reg), 32'hBEEF);
        scan(5'h02, 15, 32'h5555, -1, 0);
        chk("short_write_err", 32'(err_len), 32'h1);
        chk("short_write_irout", 32'(ir_out), 32'h2);
        chk("short_write_ctrl", 32'(ctrl_reg), 32'hBEEF);
        scan(5'h04, 1, 32'h1, -1, 0);
        chk("clear_err", 32'(err_len), 32'h0);
        scan(5'h02, 16, 32'h1234, 8, 0);
        chk("paused_write", 32'(ctrl_reg), 32'h1234);
        scan(5'h02, 10, 32'h0F0F, -1, 1);
        chk("cir_abort", 32'(ctrl_reg), 32'h1234);
        scan(5'h02, 5, 32'hAAAA, -1, 2);
        chk("reset_abort_ctrl", 32'(ctrl_reg), 32'h0);
        chk("reset_abort_irout", 32'(ir_out), 32'h0);
        scan(5'h1F, 4, 32'b1101, -1, 0);
        scan(5'h03, 16, 32'h0, -1, 0);
        scan(5'h02, 70, 32'hFFFF_FFFF, -1, 0);
        chk("sat_count_err", 32'(err_len), 32'h1);

        // simultaneous strobes: cdr beats udr, cir beats cdr, udr ignored when idle
        ir_in = 5'h02;
        cyc(UIR, 1'b0);
        cyc(CDR, 1'b0);
        repeat (3) cyc(SDR, 1'b1);
        cyc(CDR | UDR | SDR, 1'b0);
        cyc(CIR | CDR | UDR, 1'b0);
        cyc(UDR, 1'b0);
        cyc(PDR | E2 | SDR, 1'b1);

        repeat (40) begin
            status_in = DW'($urandom);
            pick = $urandom_range(0, 5);
            ir = (pick == 5) ? 5'($urandom_range(5, 31)) : 5'(pick);
            len = mlen(ir);
            n = ($urandom_range(0, 2) != 0) ? len : $urandom_range(0, len + 2);
            pa = ($urandom_range(0, 3) == 0 && n > 1) ? $urandom_range(1, n - 1) : -1;
            ek = ($urandom_range(0, 7) == 0) ? 1 : 0;
            scan(ir, n, $urandom, pa, ek);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
